rr_bus_arbiter4: RTL and testbench
==================================

// Module: rr_bus_arbiter4
// PURPOSE
//  Round-robin arbiter/sequencer that shares one 32-bit 4:1 bus mux (mux4_1x32) between four requesters.
//  Picks a winner and drives the mux select. Runs a valid/ready handshake toward the single consumer.
//  Supports locked multi-beat tenures, capped at MAX_BEATS so no requester can starve the others.
//  Sits between requester ports and the mux4_1x32 instance on the shared bus (e.g. write-back or memory port).
// PARAMETERS
//  MAX_BEATS  8   max beats per tenure when lock is held; legal range 1..255
//  CNT_W      $clog2(MAX_BEATS)+1   beat counter width (derived, do not override)
// PORTS
//  clk        in   1  single clock, rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  req        in   4  req[i]=1: requester i has a beat to send
//  lock       in   4  lock[i]=1: requester i wants to keep the grant after the current beat
//  out_ready  in   1  consumer accepts the current beat
//  gnt        out  4  one-hot grant, registered; all zero when idle
//  mux_sel    out  2  select for mux4_1x32, registered; equals index of gnt bit
//  out_valid  out  1  beat on mux output is valid = busy & req[winner]
//  beat       out  1  transfer this cycle = out_valid & out_ready
// BEHAVIOUR
//  Reset (async, reset_n=0): clears immediately, without waiting for a clock edge.
//   - state=IDLE, gnt=0, mux_sel=0, ptr=0, beat_cnt=0, winner=0.
//   - out_valid=0 and beat=0.
//  Arbitration: scan from ptr upward, mod 4. First i with req[i]=1 wins.
//  State IDLE:
//   - If any req bit is set: next edge -> BUSY, gnt=onehot(win), mux_sel=win, beat_cnt=0.
//   - Latency from req to gnt is 1 cycle.
//   - If no req bit is set: gnt=0 and mux_sel holds its last value (no select toggling).
//  State BUSY (winner w):
//   - gnt, mux_sel and w are stable until release.
//   - beat = req[w] & out_ready. Each beat increments beat_cnt.
//  Release condition, evaluated each cycle:
//   - (a) beat & !lock[w].
//   - (b) beat & beat_cnt==MAX_BEATS-1 (forced rotation, even if lock[w]=1).
//   - (c) req[w]==0 (withdrawal; no beat counted).
//  On release:
//   - ptr <= (w+1) mod 4.
//   - Re-arbitrate in the same cycle, starting from (w+1) mod 4 and using the current req.
//   - If a winner exists: next edge grants it directly, staying in BUSY with beat_cnt=0. Zero bubble cycles.
//   - Otherwise: next edge -> IDLE.
//   - w itself is eligible again only after the other three are considered.
//  Backpressure: out_ready=0 in BUSY leaves gnt, mux_sel, beat_cnt and ptr all unchanged. No timeout.
//  lock is sampled only on beat cycles. lock on a non-granted requester is ignored.
//  MAX_BEATS=1: every beat releases, regardless of lock.
//  Invariants:
//   - gnt is one-hot or zero.
//   - gnt!=0 iff state==BUSY.
//   - mux_sel==index(gnt) whenever gnt!=0.
//   - beat implies out_valid.
//  Reset mid-tenure: the beat in flight is dropped and not completed. Arbitration restarts from requester 0.
// TESTING
//  T1 Reset: req=4'b1111 while reset_n=0.
//     -> gnt=0, mux_sel=0, out_valid=0.
//     -> First edge after release: gnt=4'b0001, mux_sel=0.
//  T2 Fairness: req=4'b1111, lock=0, out_ready=1 for 8 cycles.
//     -> gnt sequence 0001,0010,0100,1000,0001,...
//     -> One beat each, beat=1 every cycle (no bubble).
//  T3 Lock cap: MAX_BEATS=8, req=4'b0101, lock=4'b0001, out_ready=1.
//     -> Requester 0 gets exactly 8 beats.
//     -> Then gnt=4'b0100 on the next edge; ptr=1.
//  T4 Backpressure: gnt=4'b0010, out_ready=0 for 5 cycles.
//     -> gnt, mux_sel=1 and beat_cnt stable; beat=0.
//     -> out_ready=1 -> beat=1 in that cycle.
//  T5 Withdrawal: requester 3 locked, req[3] falls after 2 beats, req[1]=1.
//     -> Next edge gnt=4'b0010, ptr=0, no extra beat.
//  T6 Async reset mid-tenure: reset_n=0 between clock edges during a locked burst.
//     -> gnt=0 and out_valid=0 immediately.
//     -> After release with req=4'b1000: gnt=4'b1000 one cycle later.

Source files
------------

// File: rtl/rr_bus_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_bus_arbiter4
//   Round-robin arbiter/sequencer that shares one 32-bit 4:1 bus mux between
//   four requesters. It picks a winner, drives the mux select and presents a
//   valid/ready handshake toward the single consumer. A requester may hold a
//   locked multi-beat tenure, but only for up to MAX_BEATS beats, after which
//   the grant rotates to the next requester.
//
// Ports
//   clk        in   1  clock, rising edge
//   reset_n    in   1  asynchronous active-low reset
//   req        in   4  req[i]=1: requester i has a beat to send
//   lock       in   4  lock[i]=1: requester i keeps the grant after this beat
//   out_ready  in   1  consumer accepts the current beat
//   gnt        out  4  registered one-hot grant, zero when idle
//   mux_sel    out  2  registered mux select, index of the granted requester
//   out_valid  out  1  busy & req[winner]
//   beat       out  1  out_valid & out_ready (transfer this cycle)
// -----------------------------------------------------------------------------
module rr_bus_arbiter4 #(
   parameter int MAX_BEATS = 8,
   parameter int CNT_W     = $clog2(MAX_BEATS) + 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   input  logic [3:0] lock,
   input  logic       out_ready,
   output logic [3:0] gnt,
   output logic [1:0] mux_sel,
   output logic       out_valid,
   output logic       beat
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         gnt_q, gnt_d;
   logic [1:0]         mux_sel_q, mux_sel_d;
   logic [1:0]         win_q, win_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [2:0]         idle_pick_s;
   logic [2:0]         rel_pick_s;
   logic               busy_s;
   logic               valid_s;
   logic               beat_s;
   logic               release_s;

   // Scan r starting at index 'start' upward mod 4; returns {found, index}.
   // The scan runs from the farthest offset down so the nearest hit wins.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign busy_s    = (state_q == BUSY);
   assign valid_s   = busy_s & req[win_q];
   assign beat_s    = valid_s & out_ready;

   // Candidate when starting a tenure from idle, and candidate when releasing.
   // Starting the release scan at win+1 puts the current winner last in line.
   assign idle_pick_s = rr_pick(req, ptr_q);
   assign rel_pick_s  = rr_pick(req, win_q + 2'd1);

   // Next-state, grant and counter logic.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      mux_sel_d = mux_sel_q;
      win_d     = win_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      release_s = 1'b0;

      case (state_q)
         IDLE: begin
            if (idle_pick_s[2]) begin
               state_d   = BUSY;
               win_d     = idle_pick_s[1:0];
               mux_sel_d = idle_pick_s[1:0];
               gnt_d     = 4'b0001 << idle_pick_s[1:0];
               cnt_d     = {CNT_W{1'b0}};
            end else begin
               // Select is left alone while idle to avoid toggling the mux.
               gnt_d = 4'b0000;
            end
         end
         BUSY: begin
            // Withdrawal, unlocked beat, or the beat that hits the tenure cap.
            release_s = (~req[win_q])
                      | (beat_s & ~lock[win_q])
                      | (beat_s & (cnt_q == CNT_W'(MAX_BEATS - 1)));
            if (release_s) begin
               ptr_d = win_q + 2'd1;
               if (rel_pick_s[2]) begin
                  state_d   = BUSY;
                  win_d     = rel_pick_s[1:0];
                  mux_sel_d = rel_pick_s[1:0];
                  gnt_d     = 4'b0001 << rel_pick_s[1:0];
                  cnt_d     = {CNT_W{1'b0}};
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
                  cnt_d   = {CNT_W{1'b0}};
               end
            end else if (beat_s) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and grant registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         gnt_q     <= 4'b0000;
         mux_sel_q <= 2'd0;
         win_q     <= 2'd0;
         ptr_q     <= 2'd0;
         cnt_q     <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         mux_sel_q <= mux_sel_d;
         win_q     <= win_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign mux_sel   = mux_sel_q;
   assign out_valid = valid_s;
   assign beat      = beat_s;

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
module tb_rr_bus_arbiter4;

   logic       clk;
   logic       reset_n;
   logic [3:0] req;
   logic [3:0] lock;
   logic       out_ready;
   logic [3:0] gnt;
   logic [1:0] mux_sel;
   logic       out_valid;
   logic       beat;

   int errors = 0;
   int checks = 0;

   rr_bus_arbiter4 #(.MAX_BEATS(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .lock      (lock),
      .out_ready (out_ready),
      .gnt       (gnt),
      .mux_sel   (mux_sel),
      .out_valid (out_valid),
      .beat      (beat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // T1: reset with all requesting
      reset_n   = 1'b0;
      req       = 4'b1111;
      lock      = 4'b0000;
      out_ready = 1'b1;
      #12;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_sel", 32'(mux_sel), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_beat", 32'(beat), 32'h0);
      reset_n = 1'b1;
      tick();
      check("t1_gnt", 32'(gnt), 32'h1);
      check("t1_sel", 32'(mux_sel), 32'h0);
      check("t1_beat", 32'(beat), 32'h1);

      // T2: fairness, one beat each, no bubble
      for (int i = 1; i < 8; i++) begin
         tick();
         check("t2_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
         check("t2_sel", 32'(mux_sel), 32'(i % 4));
         check("t2_beat", 32'(beat), 32'h1);
      end

      // T3: lock cap; requester 3 withdraws, requester 0 locks for 8 beats
      req  = 4'b0101;
      lock = 4'b0001;
      tick();
      for (int b = 0; b < 8; b++) begin
         check("t3_gnt", 32'(gnt), 32'h1);
         check("t3_beat", 32'(beat), 32'h1);
         check("t3_cnt", 32'(dut.cnt_q), 32'(b));
         tick();
      end
      check("t3_rot_gnt", 32'(gnt), 32'h4);
      check("t3_ptr", 32'(dut.ptr_q), 32'h1);

      // T4: backpressure on requester 1 (2 withdraws, scan from 3 finds 1)
      req       = 4'b0010;
      lock      = 4'b0000;
      out_ready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         check("t4_gnt", 32'(gnt), 32'h2);
         check("t4_sel", 32'(mux_sel), 32'h1);
         check("t4_cnt", 32'(dut.cnt_q), 32'h0);
         check("t4_ptr", 32'(dut.ptr_q), 32'h3);
         check("t4_valid", 32'(out_valid), 32'h1);
         check("t4_beat", 32'(beat), 32'h0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("t4_beat_rel", 32'(beat), 32'h1);

      // T5: requester 3 locks, withdraws after 2 beats, requester 1 waiting
      req  = 4'b1010;
      lock = 4'b1000;
      tick();
      check("t5_gnt0", 32'(gnt), 32'h8);
      check("t5_cnt0", 32'(dut.cnt_q), 32'h0);
      check("t5_beat0", 32'(beat), 32'h1);
      tick();
      check("t5_gnt1", 32'(gnt), 32'h8);
      check("t5_cnt1", 32'(dut.cnt_q), 32'h1);
      check("t5_beat1", 32'(beat), 32'h1);
      tick();
      check("t5_cnt2", 32'(dut.cnt_q), 32'h2);
      req = 4'b0010;
      #1;
      check("t5_wd_beat", 32'(beat), 32'h0);
      check("t5_wd_valid", 32'(out_valid), 32'h0);
      tick();
      check("t5_gnt", 32'(gnt), 32'h2);
      check("t5_ptr", 32'(dut.ptr_q), 32'h0);
      check("t5_cnt", 32'(dut.cnt_q), 32'h0);

      // T6: async reset mid-way through a locked burst of requester 1
      lock = 4'b0010;
      tick();
      tick();
      check("t6_pre_gnt", 32'(gnt), 32'h2);
      check("t6_pre_cnt", 32'(dut.cnt_q), 32'h2);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_gnt", 32'(gnt), 32'h0);
      check("t6_valid", 32'(out_valid), 32'h0);
      check("t6_beat", 32'(beat), 32'h0);
      check("t6_ptr", 32'(dut.ptr_q), 32'h0);
      req  = 4'b1000;
      lock = 4'b0000;
      tick();
      check("t6_hold_gnt", 32'(gnt), 32'h0);
      reset_n = 1'b1;
      tick();
      check("t6_gnt_after", 32'(gnt), 32'h8);
      check("t6_sel_after", 32'(mux_sel), 32'h3);

      // Idle: no requests, grant drops, select holds its last value
      req = 4'b0000;
      tick();
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_sel", 32'(mux_sel), 32'h3);
      check("idle_valid", 32'(out_valid), 32'h0);
      tick();
      check("idle_sel2", 32'(mux_sel), 32'h3);
      // From idle, scan starts at ptr=0 and finds requester 2
      req = 4'b0100;
      tick();
      check("idle_regnt", 32'(gnt), 32'h4);
      check("idle_resel", 32'(mux_sel), 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
